// File: rtl/bus_memory_responder.sv
// 256x8 bus-attached memory: optional zero-clear, byte-stream program load, then
// serves processor reads (asynchronous, zero latency) and writes on a shared tristate bus.
module bus_memory_responder #(
  parameter int unsigned INIT_CLEAR = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       add,
  input  logic             rd,
  input  logic             wrt,
  inout  wire  [7:0]       dat,
  input  logic             ld_valid,
  input  logic [7:0]       ld_data,
  input  logic             ld_last,
  output logic             ld_ready,
  output logic             cpu_rst,
  output logic             mem_ready,
  output logic             bus_err,
  output logic [CNT_W-1:0] rd_cnt,
  output logic [CNT_W-1:0] wr_cnt
);

  typedef enum logic [1:0] {
    ST_CLEAR,
    ST_LOAD,
    ST_RUN
  } state_t;

  localparam state_t           RESET_STATE = (INIT_CLEAR != 0) ? ST_CLEAR : ST_LOAD;
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state_q, state_d;
  logic [7:0]       ptr_q, ptr_d;
  logic             ld_ready_q, ld_ready_d;
  logic             cpu_rst_q, cpu_rst_d;
  logic             mem_ready_q, mem_ready_d;
  logic             bus_err_q, bus_err_d;
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;

  logic [7:0] mem_q [256];
  logic       mem_we;
  logic [7:0] mem_waddr;
  logic [7:0] mem_wdata;
  logic [7:0] rd_data;

  logic ld_accept;
  logic bus_rd;
  logic bus_wr;
  logic bus_conflict;

  assign ld_accept    = (state_q == ST_LOAD) && ld_valid && ld_ready_q;
  assign bus_rd       = (state_q == ST_RUN) && rd && !wrt;
  assign bus_wr       = (state_q == ST_RUN) && wrt && !rd;
  assign bus_conflict = (state_q == ST_RUN) && rd && wrt;

  // The processor samples at the edge ending the read cycle, so the read path stays combinational.
  assign rd_data = mem_q[add];
  assign dat     = bus_rd ? rd_data : 8'bz;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    ld_ready_d  = ld_ready_q;
    cpu_rst_d   = cpu_rst_q;
    mem_ready_d = mem_ready_q;
    bus_err_d   = bus_err_q;
    rd_cnt_d    = rd_cnt_q;
    wr_cnt_d    = wr_cnt_q;
    mem_we      = 1'b0;
    mem_waddr   = ptr_q;
    mem_wdata   = 8'h00;

    unique case (state_q)
      ST_CLEAR: begin
        ld_ready_d = 1'b0;
        mem_we     = 1'b1;
        ptr_d      = ptr_q + 8'd1;
        if (ptr_q == 8'hFF) begin
          state_d = ST_LOAD;
          ptr_d   = 8'h00;
        end
      end

      ST_LOAD: begin
        ld_ready_d = 1'b1;
        if (ld_accept) begin
          mem_we    = 1'b1;
          mem_wdata = ld_data;
          ptr_d     = ptr_q + 8'd1;
          // The 256th byte ends the load even without ld_last, so ptr never wraps here.
          if (ld_last || (ptr_q == 8'hFF)) begin
            state_d     = ST_RUN;
            ld_ready_d  = 1'b0;
            cpu_rst_d   = 1'b0;
            mem_ready_d = 1'b1;
          end
        end
      end

      ST_RUN: begin
        ld_ready_d = 1'b0;
        if (bus_conflict) begin
          bus_err_d = 1'b1;
        end else if (bus_rd) begin
          if (rd_cnt_q != CNT_MAX) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
          end
        end else if (bus_wr) begin
          mem_we    = 1'b1;
          mem_waddr = add;
          mem_wdata = dat;
          if (wr_cnt_q != CNT_MAX) begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = RESET_STATE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= RESET_STATE;
      ptr_q       <= 8'h00;
      ld_ready_q  <= 1'b0;
      cpu_rst_q   <= 1'b1;
      mem_ready_q <= 1'b0;
      bus_err_q   <= 1'b0;
      rd_cnt_q    <= '0;
      wr_cnt_q    <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      ld_ready_q  <= ld_ready_d;
      cpu_rst_q   <= cpu_rst_d;
      mem_ready_q <= mem_ready_d;
      bus_err_q   <= bus_err_d;
      rd_cnt_q    <= rd_cnt_d;
      wr_cnt_q    <= wr_cnt_d;
    end
  end

  // Array contents survive reset; only writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign ld_ready  = ld_ready_q;
  assign cpu_rst   = cpu_rst_q;
  assign mem_ready = mem_ready_q;
  assign bus_err   = bus_err_q;
  assign rd_cnt    = rd_cnt_q;
  assign wr_cnt    = wr_cnt_q;

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed bench for bus_memory_responder: a cycle-level behavioural model is compared
// on every falling edge, plus hand-computed literal expectations for each scenario.
module tb_bus_memory_responder;

  localparam int CW   = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    add;
  logic          rd;
  logic          wrt;
  wire  [7:0]    dat;
  logic          ld_valid;
  logic [7:0]    ld_data;
  logic          ld_last;
  logic          ld_ready;
  logic          cpu_rst;
  logic          mem_ready;
  logic          bus_err;
  logic [CW-1:0] rd_cnt;
  logic [CW-1:0] wr_cnt;

  // Processor side of the shared bus.
  logic       drv_en;
  logic [7:0] drv_val;
  assign dat = drv_en ? drv_val : 8'bz;

  int checks = 0;
  int errors = 0;

  bus_memory_responder #(.INIT_CLEAR(1), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .add(add), .rd(rd), .wrt(wrt), .dat(dat),
    .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
    .ld_ready(ld_ready), .cpu_rst(cpu_rst), .mem_ready(mem_ready),
    .bus_err(bus_err), .rd_cnt(rd_cnt), .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: phases tracked by remaining clear cycles, load count and a run flag.
  logic [7:0] mem_m [256];
  bit m_valid = 0;
  int m_clr_left, m_lcount, m_rdc, m_wrc;
  bit m_run, m_ldr, m_err;

  always @(posedge clk) begin
    if (!rst) begin
      m_valid    = 1;
      m_clr_left = 256;
      m_lcount   = 0;
      m_run      = 0;
      m_ldr      = 0;
      m_err      = 0;
      m_rdc      = 0;
      m_wrc      = 0;
    end else if (m_valid) begin
      if (m_clr_left > 0) begin
        mem_m[256 - m_clr_left] = 8'h00;
        m_clr_left--;
      end else if (!m_run) begin
        if (m_ldr && ld_valid) begin
          mem_m[m_lcount] = ld_data;
          m_lcount++;
          if (ld_last || m_lcount == 256) begin
            m_run = 1;
            m_ldr = 0;
          end
        end else begin
          m_ldr = 1;
        end
      end else begin
        if (rd && wrt) m_err = 1;
        else if (rd) m_rdc = (m_rdc < CMAX) ? m_rdc + 1 : CMAX;
        else if (wrt) begin
          mem_m[add] = drv_val;
          m_wrc = (m_wrc < CMAX) ? m_wrc + 1 : CMAX;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("ld_ready", int'(ld_ready), int'(m_ldr));
      chk("cpu_rst", int'(cpu_rst), int'(!m_run));
      chk("mem_ready", int'(mem_ready), int'(m_run));
      chk("bus_err", int'(bus_err), int'(m_err));
      chk("rd_cnt", int'(rd_cnt), m_rdc);
      chk("wr_cnt", int'(wr_cnt), m_wrc);
      if (m_run && rd && !wrt && !drv_en) chk("dat_read", int'(dat), int'(mem_m[add]));
      else if (drv_en) chk("dat_nodrive", int'(dat), int'(drv_val));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    step();
    chk("rst_cpu_rst", int'(cpu_rst), 1);
    chk("rst_ld_ready", int'(ld_ready), 0);
    chk("rst_mem_ready", int'(mem_ready), 0);
    chk("rst_bus_err", int'(bus_err), 0);
    chk("rst_rd_cnt", int'(rd_cnt), 0);
    step();
    rst = 1'b1;
  endtask

  task automatic wait_ldr();
    int n = 0;
    while (!ld_ready && n < 400) begin
      step();
      n++;
    end
    chk("ld_ready_rise_cycles", n, 257);
  endtask

  task automatic load_byte(input logic [7:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data  = d;
    ld_last  = last;
    step();
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [7:0] a, input logic [7:0] exp);
    drv_en = 1'b0;
    add    = a;
    rd     = 1'b1;
    @(negedge clk);
    chk(name, int'(dat), int'(exp));
    step();
    rd     = 1'b0;
    drv_en = 1'b1;
  endtask

  task automatic bus_write(input logic [7:0] a, input logic [7:0] v);
    drv_en  = 1'b1;
    drv_val = v;
    add     = a;
    wrt     = 1'b1;
    @(negedge clk);
    chk("write_cycle_dat_undriven", int'(dat), int'(v));
    step();
    wrt     = 1'b0;
    drv_val = 8'h00;
  endtask

  initial begin
    rst = 1'b0; add = 8'h00; rd = 1'b0; wrt = 1'b0;
    ld_valid = 1'b0; ld_data = 8'h00; ld_last = 1'b0;
    drv_en = 1'b1; drv_val = 8'h00;

    // Clear then empty load
    do_reset();
    wait_ldr();
    load_byte(8'h00, 1'b1);
    chk("empty_load_mem_ready", int'(mem_ready), 1);
    chk("empty_load_cpu_rst", int'(cpu_rst), 0);
    bus_read("read_7f_cleared", 8'h7F, 8'h00);

    // Three-byte load
    do_reset();
    wait_ldr();
    load_byte(8'h21, 1'b0);
    load_byte(8'h40, 1'b0);
    load_byte(8'h95, 1'b1);
    chk("load3_mem_ready", int'(mem_ready), 1);
    bus_read("load3_read_00", 8'h00, 8'h21);
    bus_read("load3_read_01", 8'h01, 8'h40);
    bus_read("load3_read_02", 8'h02, 8'h95);
    chk("load3_rd_cnt", int'(rd_cnt), 3);

    // Full 256-byte load, ld_last never set
    do_reset();
    wait_ldr();
    ld_valid = 1'b1;
    ld_last  = 1'b0;
    for (int i = 0; i < 256; i++) begin
      ld_data = 8'(i);
      step();
    end
    ld_data = 8'hEE;
    @(negedge clk);
    chk("full_257th_not_ready", int'(ld_ready), 0);
    chk("full_mem_ready", int'(mem_ready), 1);
    step();
    ld_valid = 1'b0;
    bus_read("full_read_ff", 8'hFF, 8'hFF);
    bus_read("full_read_00_no_wrap", 8'h00, 8'h00);

    // Write then read back
    bus_write(8'h10, 8'hA5);
    chk("write_wr_cnt", int'(wr_cnt), 1);
    bus_read("write_readback", 8'h10, 8'hA5);

    // Conflict
    drv_val = 8'h3C; add = 8'h10; rd = 1'b1; wrt = 1'b1;
    @(negedge clk);
    chk("conflict_dat_undriven", int'(dat), 8'h3C);
    step();
    rd = 1'b0; wrt = 1'b0; drv_val = 8'h00;
    chk("conflict_bus_err", int'(bus_err), 1);
    repeat (5) step();
    chk("conflict_bus_err_sticky", int'(bus_err), 1);
    chk("conflict_rd_cnt", int'(rd_cnt), 3);
    chk("conflict_wr_cnt", int'(wr_cnt), 1);
    bus_read("conflict_mem_kept", 8'h10, 8'hA5);

    // Counter saturation
    for (int i = 0; i < 16; i++) bus_read("sat_read", 8'(i), 8'(i));
    chk("rd_cnt_saturated", int'(rd_cnt), CMAX);
    for (int i = 0; i < 20; i++) bus_write(8'(8'h80 + i), 8'(i * 3));
    chk("wr_cnt_saturated", int'(wr_cnt), CMAX);
    bus_read("sat_write_readback", 8'h85, 8'h0F);

    // Mid-load reset
    do_reset();
    wait_ldr();
    load_byte(8'h11, 1'b0);
    load_byte(8'h22, 1'b0);
    rst = 1'b0;
    step();
    chk("midload_cpu_rst", int'(cpu_rst), 1);
    chk("midload_ld_ready", int'(ld_ready), 0);
    step();
    rst = 1'b1;
    wait_ldr();
    load_byte(8'h00, 1'b1);
    bus_read("midload_read_00", 8'h00, 8'h00);
    bus_read("midload_read_01_recleared", 8'h01, 8'h00);

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_memory_responder.md
Name: bus_memory_responder

Overview:
- 256x8 memory that answers the processor's shared bus: `add[7:0]`, `rd`, `wrt`, bidirectional `dat[7:0]`.
- After reset, it optionally zero-clears the array, then accepts a program image over a byte-stream load port.
- While clearing and loading, it holds the processor in reset through `cpu_rst`.
- In RUN, it serves bus reads (drives `dat`) and bus writes (samples `dat`), and keeps access counters and a protocol-error flag.

Parameters:
- `INIT_CLEAR`, default 1: 1 means zero all 256 locations before LOAD; 0 means go straight to LOAD.
- `CNT_W`, default 16: width of the read and write access counters.

Ports:
- `clk` input 1: single clock, rising edge.
- `rst` input 1: synchronous, active-low reset.
- `add` input 8: bus address from the processor.
- `rd` input 1: bus read strobe, active high.
- `wrt` input 1: bus write strobe, active high.
- `dat` inout 8: shared data bus; driven only during a valid read, high-Z otherwise.
- `ld_valid` input 1: load byte valid.
- `ld_data` input 8: load byte.
- `ld_last` input 1: marks the final load byte; qualified by `ld_valid`.
- `ld_ready` output 1: block accepts load bytes this cycle.
- `cpu_rst` output 1: active-high reset to the processor.
- `mem_ready` output 1: high in RUN.
- `bus_err` output 1: sticky protocol error.
- `rd_cnt` output CNT_W: count of served reads.
- `wr_cnt` output CNT_W: count of performed writes.

Behaviour:
- Reset (`rst`==0 at a rising clk edge):
  - state goes to CLEAR if `INIT_CLEAR`, else LOAD; `ptr` goes to 0.
  - Outputs: `cpu_rst`=1, `ld_ready`=0, `mem_ready`=0, `bus_err`=0, `rd_cnt`=0, `wr_cnt`=0, `dat`=Z.
  - Array contents are not reset.
  - A reset asserted mid-operation from any state aborts that state the same way.
- CLEAR state:
  - Each cycle: mem[`ptr`]<=0, `ptr`<=`ptr`+1.
  - At `ptr`==255, go to LOAD with `ptr`<=0. CLEAR lasts exactly 256 cycles.
  - `ld_ready`=0; load inputs are ignored.
- LOAD state:
  - `ld_ready`=1 (registered, asserted the cycle after entering LOAD).
  - Accept when `ld_valid`&&`ld_ready`: mem[`ptr`]<=`ld_data`, `ptr`<=`ptr`+1.
  - Terminating conditions, both evaluated on an accepted byte: `ld_last`==1, or `ptr`==255 (256th byte).
  - On termination: go to RUN, drop `ld_ready` the next cycle, write no further bytes. A byte with `ld_last` is itself written.
  - `ld_last` without `ld_valid` has no effect.
  - No wrap: `ptr` never returns to 0 inside LOAD.
- RUN state:
  - On the entry edge, `cpu_rst`<=0 and `mem_ready`<=1. RUN persists until reset; the load port is ignored.
- Bus read (RUN, `rd`=1, `wrt`=0):
  - `dat` = mem[`add`] combinationally (asynchronous read).
  - The processor raises `rd` at edge N and samples at edge N+1, so data must be stable within that cycle; zero-cycle read latency is mandatory.
  - `rd_cnt` increments once per cycle `rd` is high. The processor holds `rd` for exactly one cycle per access.
- Bus write (RUN, `wrt`=1, `rd`=0):
  - mem[`add`]<=`dat` at the rising edge ending the cycle; `wr_cnt`+1.
  - `dat` is never driven by this block while `wrt`=1.
  - A read of the same address in the next cycle returns the new value.
- Conflict (RUN, `rd`=1 and `wrt`=1):
  - No drive (`dat`=Z), no write, no counter change.
  - `bus_err`<=1, sticky until reset.
- Outside RUN: `dat` is always Z, `rd`/`wrt` are ignored, counters are frozen.
- Counters saturate at 2^CNT_W-1 and never wrap.
- `dat` Z whenever not actively reading; no other driver condition exists.

Test Plan:
- Clear then empty load: `rst`=0 for 2 cycles then 1, `INIT_CLEAR`=1, no load bytes. Required: `ld_ready` rises 257 cycles after release; after `ld_valid`=1, `ld_data`=0x00, `ld_last`=1, `mem_ready`=1 and `cpu_rst`=0 one cycle later; bus read of 0x7F returns 0x00.
- Load 3 bytes: 0x21, 0x40, 0x95 with `ld_last` on the third. Required: RUN entered; reads at `add` 0x00/0x01/0x02 return 0x21/0x40/0x95; `rd_cnt`=3.
- Full load: 256 bytes with value=address, `ld_last` never set. Required: RUN after the 256th byte; mem[0xFF]=0xFF; the 257th `ld_valid` is not accepted (`ld_ready`=0).
- Write then read back: processor-style `wrt`=1, `add`=0x10, `dat`=0xA5 for one cycle, then `rd`=1, `add`=0x10. Required: `dat`=0xA5 during the read cycle; `wr_cnt`=1; `dat`=Z during the write cycle from this side.
- Conflict: `rd`=`wrt`=1, `add`=0x10, `dat`=0x3C. Required: mem[0x10] stays 0xA5, `dat` not driven, `bus_err`=1 and still 1 after 5 idle cycles, counters unchanged.
- Mid-load reset: `rst`=0 after 2 accepted bytes. Required: next cycle `cpu_rst`=1, `ld_ready`=0, state CLEAR; after a re-clear, address 0x00 reads 0x00 once RUN is reached with an empty-load (`ld_last`) byte 0x00.
